rr_mux_arb: RTL and testbench

//  Parametrised successor of the 4-way 16-bit mux: N-way, W-bit, valid/ready channel mux.

---
 rtl/rr_mux_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 100 ++++++++++
 rtl/rr_mux_arb.sv | 88 ++++++++
 tb/tb_rr_mux_arb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin channel mux.
// Optional feature macro: RR_MUX_ARB_FORCE_EN (adds a forced-select override).
package rr_mux_pkg;

  // Upper bound on channel-index width. Index arithmetic is done at this
  // width before it is truncated to the instance's CH_W.
  localparam int CH_IDX_MAX_W = 16;

  // Wide channel index used for modular index arithmetic.
  typedef logic [CH_IDX_MAX_W-1:0] ch_idx_t;

  // $clog2 with a minimum of 1. A single-channel instance still gets a
  // 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : rr_mux_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. It owns the priority pointer and produces both a
// one-hot grant and the binary index of the winner.
// Optional feature macro: RR_MUX_ARB_FORCE_EN. It adds force_en_i and
// force_sel_i, which pin the grant to one channel and freeze the pointer.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int CH_W = clog2_min1(N)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
`ifdef RR_MUX_ARB_FORCE_EN
  input  logic            force_en_i,
  input  logic [CH_W-1:0] force_sel_i,
`endif
  output logic [N-1:0]    grant_o,
  output logic [CH_W-1:0] grant_idx_o,
  output logic            grant_valid_o
);

  logic [CH_W-1:0] ptr_reg;
  logic [CH_W-1:0] ptr_next;
  logic [2*N-1:0]  req_rot_wide;
  logic [N-1:0]    req_rot;
  logic [CH_W-1:0] rr_offset;
  logic            rr_found;
  ch_idx_t         idx_sum;
  logic [CH_W-1:0] rr_idx;
  logic            hold_ptr;

  // Rotate the requests so that the channel at ptr sits at bit 0.
  // The doubled vector makes the rotation wrap without a modulo.
  assign req_rot_wide = {req_i, req_i} >> ptr_reg;
  assign req_rot      = req_rot_wide[N-1:0];

  // Find the lowest set bit of the rotated requests. This is the distance
  // from ptr to the winning channel.
  always_comb begin
    rr_found  = 1'b0;
    rr_offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rr_found  = 1'b1;
        rr_offset = CH_W'(i);
      end
    end
  end

  // Map the distance back to an absolute channel index, modulo N.
  assign idx_sum = ch_idx_t'(ptr_reg) + ch_idx_t'(rr_offset);
  assign rr_idx  = (idx_sum >= ch_idx_t'(N)) ? CH_W'(idx_sum - ch_idx_t'(N))
                                             : CH_W'(idx_sum);

`ifdef RR_MUX_ARB_FORCE_EN
  logic [N-1:0] force_req_sh;
  assign force_req_sh = req_i >> force_sel_i;

  // While forced, only the selected channel can win, and only if it is
  // valid. An out-of-range select never wins.
  always_comb begin
    grant_valid_o = rr_found;
    grant_idx_o   = rr_idx;
    hold_ptr      = 1'b0;
    if (force_en_i) begin
      grant_valid_o = (ch_idx_t'(force_sel_i) < ch_idx_t'(N)) & force_req_sh[0];
      grant_idx_o   = force_sel_i;
      hold_ptr      = 1'b1;
    end
  end
`else
  assign grant_valid_o = rr_found;
  assign grant_idx_o   = rr_idx;
  assign hold_ptr      = 1'b0;
`endif

  // Expand the binary index into a one-hot grant.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign grant_o[gi] = grant_valid_o & (grant_idx_o == CH_W'(gi));
    end
  endgenerate

  // After a grant, priority moves to the channel just past the winner.
  // With N=1 this always evaluates to 0.
  assign ptr_next = (grant_idx_o == CH_W'(N - 1)) ? '0 : grant_idx_o + CH_W'(1);

  // The pointer advances only on an actual transfer, and never while forced.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_reg <= '0;
    end else if (advance_i && grant_valid_o && !hold_ptr) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule : rr_arbiter

// File: rtl/rr_mux_arb.sv
// N-way, W-bit valid/ready channel mux with round-robin arbitration and a
// single registered output stage (1-cycle latency, 1 word/cycle).
// Optional feature macro: RR_MUX_ARB_FORCE_EN (adds force_en_i/force_sel_i).
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 16,
  localparam int CH_W = clog2_min1(N)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [N-1:0]    in_valid_i,
  input  logic [N*W-1:0]  in_data_i,
  output logic [N-1:0]    in_ready_o,
`ifdef RR_MUX_ARB_FORCE_EN
  input  logic            force_en_i,
  input  logic [CH_W-1:0] force_sel_i,
`endif
  output logic            out_valid_o,
  output logic [W-1:0]    out_data_o,
  output logic [CH_W-1:0] out_ch_o,
  input  logic            out_ready_i
);

  logic            out_valid_reg;
  logic [W-1:0]    out_data_reg;
  logic [CH_W-1:0] out_ch_reg;
  logic            load;
  logic [N-1:0]    grant;
  logic [CH_W-1:0] grant_idx;
  logic            grant_valid;
  logic [W-1:0]    sel_data;
  logic [W-1:0]    data_arr [N];

  // The output stage can take a word when it is empty or is being drained.
  assign load = !out_valid_reg | out_ready_i;

  rr_arbiter #(
    .N (N)
  ) u_arbiter (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .req_i         (in_valid_i),
    .advance_i     (load),
`ifdef RR_MUX_ARB_FORCE_EN
    .force_en_i    (force_en_i),
    .force_sel_i   (force_sel_i),
`endif
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  // Unpack the flat input bus into one word per channel.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign data_arr[gi] = in_data_i[gi*W +: W];
    end
  endgenerate

  assign sel_data   = data_arr[grant_idx];
  assign in_ready_o = grant & {N{load}};

  // Output stage. Load the winner, go empty when there is nothing to
  // take, and hold everything under backpressure.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= sel_data;
        out_ch_reg    <= grant_idx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign out_ch_o    = out_ch_reg;

endmodule : rr_mux_arb

// File: tb/tb_rr_mux_arb.sv
// Directed testbench for rr_mux_arb: N=4/W=16 main instance plus an N=1/W=8
// instance acting as a plain register slice.
// Optional feature macro: RR_MUX_ARB_FORCE_EN (enables the forced-select steps).
module tb_rr_mux_arb;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  in_valid_i;
  logic [63:0] in_data_i;
  logic [3:0]  in_ready_o;
  logic        out_valid_o;
  logic [15:0] out_data_o;
  logic [1:0]  out_ch_o;
  logic        out_ready_i;

  logic        v1;
  logic [7:0]  d1;
  logic        rdy1;
  logic        ov1;
  logic [7:0]  od1;
  logic [0:0]  och1;
  logic        ordy1;

`ifdef RR_MUX_ARB_FORCE_EN
  logic        force_en_i;
  logic [1:0]  force_sel_i;
  logic        force_en1;
  logic [0:0]  force_sel1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  rr_mux_arb #(.N(4), .W(16)) u_dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
`ifdef RR_MUX_ARB_FORCE_EN
    .force_en_i  (force_en_i),
    .force_sel_i (force_sel_i),
`endif
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ch_o    (out_ch_o),
    .out_ready_i (out_ready_i)
  );

  rr_mux_arb #(.N(1), .W(8)) u_dut1 (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (v1),
    .in_data_i   (d1),
    .in_ready_o  (rdy1),
`ifdef RR_MUX_ARB_FORCE_EN
    .force_en_i  (force_en1),
    .force_sel_i (force_sel1),
`endif
    .out_valid_o (ov1),
    .out_data_o  (od1),
    .out_ch_o    (och1),
    .out_ready_i (ordy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, v});
    chk({tag, ".data"},  {16'd0, out_data_o},  {16'd0, d});
    chk({tag, ".ch"},    {30'd0, out_ch_o},    {30'd0, c});
  endtask

  initial begin
    rst_n_i     = 1'b0;
    in_valid_i  = 4'b0000;
    in_data_i   = 64'd0;
    out_ready_i = 1'b1;
    v1          = 1'b0;
    d1          = 8'd0;
    ordy1       = 1'b1;
`ifdef RR_MUX_ARB_FORCE_EN
    force_en_i  = 1'b0;
    force_sel_i = 2'd0;
    force_en1   = 1'b0;
    force_sel1  = 1'b0;
`endif

    // Reset state
    repeat (2) tick();
    chk_out("reset", 1'b0, 16'h0000, 2'd0);
    chk("reset.in_ready", {28'd0, in_ready_o}, 32'h0);
    chk("reset.n1_valid", {31'd0, ov1}, 32'h0);
    $display("step reset: valid=%0b data=%h ch=%0d", out_valid_o, out_data_o, out_ch_o);
    rst_n_i = 1'b1;

    // All channels valid, consumer always ready: ch 0,1,2,3,0 at one per cycle
    in_valid_i = 4'b1111;
    in_data_i  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    #1;
    chk("rr.first_ready", {28'd0, in_ready_o}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, 16'hA000 + 16'(i % 4), 2'(i % 4));
      chk($sformatf("rr%0d.in_ready", i), {28'd0, in_ready_o}, 32'(1 << ((i + 1) % 4)));
      $display("step rr%0d: ch=%0d data=%h in_ready=%b", i, out_ch_o, out_data_o, in_ready_o);
    end

    // Backpressure for 5 cycles: output frozen, no grant, ptr frozen at 1
    out_ready_i = 1'b0;
    #1;
    chk("bp.in_ready0", {28'd0, in_ready_o}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("bp%0d", i), 1'b1, 16'hA000, 2'd0);
      chk($sformatf("bp%0d.in_ready", i), {28'd0, in_ready_o}, 32'h0);
      $display("step bp%0d: ch=%0d data=%h in_ready=%b", i, out_ch_o, out_data_o, in_ready_o);
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp.release_ready", {28'd0, in_ready_o}, 32'h2);
    tick();
    chk_out("bp.release", 1'b1, 16'hA001, 2'd1);
    $display("step bp.release: ch=%0d data=%h", out_ch_o, out_data_o);

    // Sole valid channel 2 is granted every cycle
    in_valid_i = 4'b0100;
    in_data_i  = {16'hA003, 16'h1234, 16'hA001, 16'hA000};
    #1;
    chk("solo.in_ready_first", {28'd0, in_ready_o}, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("solo%0d", i), 1'b1, 16'h1234, 2'd2);
      chk($sformatf("solo%0d.in_ready", i), {28'd0, in_ready_o}, 32'h4);
      $display("step solo%0d: ch=%0d data=%h in_ready=%b", i, out_ch_o, out_data_o, in_ready_o);
    end

    // ptr=3, valid=0011: wrap to ch0, then ch1; ptr ends at 2
    in_valid_i = 4'b0011;
    in_data_i  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    #1;
    chk("wrap.in_ready0", {28'd0, in_ready_o}, 32'h1);
    tick();
    chk_out("wrap0", 1'b1, 16'hA000, 2'd0);
    chk("wrap.in_ready1", {28'd0, in_ready_o}, 32'h2);
    $display("step wrap0: ch=%0d data=%h", out_ch_o, out_data_o);
    tick();
    chk_out("wrap1", 1'b1, 16'hA001, 2'd1);
    $display("step wrap1: ch=%0d data=%h", out_ch_o, out_data_o);
    in_valid_i = 4'b0000;
    #1;
    chk("idle.in_ready", {28'd0, in_ready_o}, 32'h0);
    tick();
    chk_out("idle", 1'b0, 16'hA001, 2'd1);
    $display("step idle: valid=%0b ch=%0d data=%h", out_valid_o, out_ch_o, out_data_o);
    in_valid_i = 4'b1111;
    #1;
    chk("wrap.ptr_end", {28'd0, in_ready_o}, 32'h4);

    // Reset mid-transfer: asynchronous clear, then restart at channel 0
    tick();
    chk_out("pre_rst", 1'b1, 16'hA002, 2'd2);
    $display("step pre_rst: ch=%0d data=%h", out_ch_o, out_data_o);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 16'h0000, 2'd0);
    $display("step async_rst: valid=%0b data=%h ch=%0d", out_valid_o, out_data_o, out_ch_o);
    #2;
    rst_n_i = 1'b1;
    #1;
    chk("post_rst.in_ready", {28'd0, in_ready_o}, 32'h1);
    tick();
    chk_out("post_rst", 1'b1, 16'hA000, 2'd0);
    $display("step post_rst: ch=%0d data=%h", out_ch_o, out_data_o);

`ifdef RR_MUX_ARB_FORCE_EN
    // Force ch1 with all valid; ptr (=1) must stay put
    force_en_i  = 1'b1;
    force_sel_i = 2'd1;
    #1;
    chk("force.in_ready", {28'd0, in_ready_o}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("force%0d", i), 1'b1, 16'hA001, 2'd1);
      $display("step force%0d: ch=%0d data=%h", i, out_ch_o, out_data_o);
    end
    force_en_i = 1'b0;
    #1;
    chk("unforce.in_ready", {28'd0, in_ready_o}, 32'h2);
    tick();
    chk_out("unforce", 1'b1, 16'hA001, 2'd1);
    $display("step unforce: ch=%0d data=%h", out_ch_o, out_data_o);
`endif

    // N=1 instance acts as a 1-deep register slice
    v1 = 1'b1;
    d1 = 8'h5A;
    #1;
    chk("n1.in_ready", {31'd0, rdy1}, 32'h1);
    tick();
    chk("n1.valid", {31'd0, ov1}, 32'h1);
    chk("n1.data", {24'd0, od1}, 32'h5A);
    chk("n1.ch", {31'd0, och1}, 32'h0);
    $display("step n1.load: valid=%0b data=%h", ov1, od1);
    ordy1 = 1'b0;
    #1;
    chk("n1.bp_ready", {31'd0, rdy1}, 32'h0);
    v1    = 1'b0;
    ordy1 = 1'b1;
    tick();
    chk("n1.drain", {31'd0, ov1}, 32'h0);
    chk("n1.hold_data", {24'd0, od1}, 32'h5A);
    $display("step n1.drain: valid=%0b data=%h", ov1, od1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rr_mux_arb
